// File: rtl/fetch_pkg.sv
// Shared types and default window constants for the instruction fetch sequencer.
package fetch_pkg;

   localparam logic [31:0] DEF_BASE_ADDR = 32'hBFC00000;
   localparam int unsigned DEF_MEM_SIZE  = 4096;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of {pc, instr} entries; flush wins over push and pop.
module fetch_buf
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  fetch_entry_t             i_data,
   output fetch_entry_t             o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_pop;
   logic          w_push;

   // A push into a full buffer is only allowed when the head leaves the same cycle.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_FULL);
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: walks the instruction window, buffers {pc, instr} and
// handles redirects and redirect faults.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
   parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
   parameter int          DEPTH     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_rdata_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   input  logic        instr_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        fault_o,
   output logic [31:0] fault_addr_o
);

   localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(MEM_SIZE) - 32'd4;

   fetch_state_t            r_state;
   fetch_state_t            w_state_nxt;
   logic [31:0]             r_fetch_pc;
   logic [31:0]             w_fetch_pc_nxt;
   logic                    r_fault;
   logic                    w_fault_nxt;
   logic [31:0]             r_fault_addr;
   logic [31:0]             w_fault_addr_nxt;
   logic                    w_legal;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [$clog2(DEPTH):0]  w_count;
   fetch_entry_t            w_head;
   fetch_entry_t            w_new_entry;

   assign w_legal = (redirect_pc_i[1:0] == 2'b00) &&
                    (redirect_pc_i >= BASE_ADDR) && (redirect_pc_i <= LAST_ADDR);

   assign w_pop       = !w_empty && instr_ready_i;
   assign w_push      = (r_state == RUN) && !redirect_i && (!w_full || w_pop);
   assign w_new_entry = '{pc: r_fetch_pc, instr: mem_rdata_i};

   always_comb begin
      w_state_nxt      = r_state;
      w_fetch_pc_nxt   = r_fetch_pc;
      w_fault_nxt      = r_fault;
      w_fault_addr_nxt = r_fault_addr;
      if (redirect_i) begin
         if (w_legal) begin
            w_state_nxt      = RUN;
            w_fetch_pc_nxt   = redirect_pc_i;
            w_fault_nxt      = 1'b0;
            w_fault_addr_nxt = '0;
         end else begin
            w_state_nxt      = FAULT;
            w_fault_nxt      = 1'b1;
            w_fault_addr_nxt = redirect_pc_i;
         end
      end else begin
         case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN: begin
               if (w_push) begin
                  w_fetch_pc_nxt = (r_fetch_pc == LAST_ADDR) ? BASE_ADDR : r_fetch_pc + 32'd4;
               end
            end
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= BOOT;
         r_fetch_pc   <= BASE_ADDR;
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_fetch_pc   <= w_fetch_pc_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_addr <= w_fault_addr_nxt;
      end
   end

   fetch_buf #(.DEPTH(DEPTH)) u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_i),
      .i_data  (w_new_entry),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Entering FAULT always flushes, so an empty buffer covers that state too.
   assign instr_valid_o = !w_empty;
   assign instr_o       = w_empty ? '0 : w_head.instr;
   assign pc_o          = w_empty ? '0 : w_head.pc;
   assign mem_addr_o    = r_fetch_pc;
   assign fault_o       = r_fault;
   assign fault_addr_o  = r_fault_addr;

endmodule
